// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state codes,
// forwarding select encodings and the default register-number width.
package pipe_hazard_ctrl_pkg;

  localparam int DEF_REG_AW = 5;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational forwarding select for one EXE operand; the newer MEM-stage
// result beats WB, and register $0 is never forwarded.
module hazard_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] ex_src,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_src))
      fwd = FWD_MEM;
    else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_src))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline: memory-wait
// FSM with timeout, priority-ordered register controls and saturating counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int REG_AW      = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_redirect,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_clr,
  output logic              idexe_we,
  output logic              idexe_clr,
  output logic              exemem_we,
  output logic              exemem_clr,
  output logic              memwb_we,
  output logic              memwb_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT);

  logic [0:0]     state;
  logic [WCW-1:0] wait_cnt;
  logic           timeout;
  logic           mem_stall;
  logic           load_use;
  logic           stall_event;
  logic           flush_event;
  logic [1:0]     fwd_a_raw;
  logic [1:0]     fwd_b_raw;

  assign timeout   = (state == ST_MEM_WAIT) && (wait_cnt == WCW'(MEM_TIMEOUT - 1));
  assign mem_stall = ((state == ST_RUN) && mem_req && !mem_ready) ||
                     ((state == ST_MEM_WAIT) && !mem_ready && !timeout);

  assign load_use = ex_memread && ex_regwrite && (ex_wreg != '0) &&
                    ((id_uses_rs && (id_rs == ex_wreg)) ||
                     (id_uses_rt && (id_rt == ex_wreg)));

  // A redirect seen during a memory stall is held in EXE, so it only counts once released.
  assign stall_event = mem_stall || (!ex_redirect && load_use);
  assign flush_event = !mem_stall && ex_redirect;

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_clr   = 1'b0;
    idexe_we   = 1'b1;
    idexe_clr  = 1'b0;
    exemem_we  = 1'b1;
    exemem_clr = 1'b0;
    memwb_we   = 1'b1;
    memwb_clr  = 1'b0;
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_clr   = 1'b1;
      idexe_we   = 1'b0;
      idexe_clr  = 1'b1;
      exemem_we  = 1'b0;
      exemem_clr = 1'b1;
      memwb_we   = 1'b0;
      memwb_clr  = 1'b1;
    end else if (mem_stall) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idexe_we  = 1'b0;
      exemem_we = 1'b0;
      memwb_clr = 1'b1;
    end else if (ex_redirect) begin
      ifid_clr  = 1'b1;
      idexe_clr = 1'b1;
    end else if (load_use) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idexe_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        default: begin
          if (mem_ready || timeout)
            state <= ST_RUN;
          else
            wait_cnt <= wait_cnt + WCW'(1);
          if (timeout)
            mem_err <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cnt    <= '0;
    end else begin
      if (stall_event && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_event && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_src       (ex_rs),
    .mem_regwrite (mem_regwrite),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .fwd          (fwd_a_raw)
  );

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_src       (ex_rt),
    .mem_regwrite (mem_regwrite),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .fwd          (fwd_b_raw)
  );

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;

endmodule
